// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Brief    : Shared op codes, sequencer states and op-legality helper for the
//            F-type issue sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [3:0] {
        FADD = 4'b0000,
        FSUB = 4'b0001,
        FMUL = 4'b0010,
        FDIV = 4'b0011,
        FABS = 4'b0100,
        FNEG = 4'b0101
    } fpu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WB   = 2'd2
    } seq_state_t;

    function automatic logic is_legal_fpu_op(input logic [3:0] op);
        return (op <= 4'b0101);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_sign_unit.sv
`default_nettype none
// ============================================================================
// Module   : fpu_sign_unit
// Brief    : Combinational sign manipulation (ABS clears, NEG flips the sign).
// Revision : 1.0 - initial release
// ============================================================================
module fpu_sign_unit
    import fpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  fpu_op_t          op,
    output logic [WIDTH-1:0] y
);

    logic w_sign;

    assign w_sign = (op == FNEG) ? ~a[WIDTH-1] : 1'b0;
    assign y      = {w_sign, a[WIDTH-2:0]};

endmodule
`default_nettype wire

// File: rtl/fpu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_seq
// Brief    : Accepts F-type ops in EX, runs them locally or on the external
//            FP datapath, stalls the pipeline while busy, writes one result.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_seq
    import fpu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               issue_valid,
    input  logic [3:0]         fpu_control,
    input  logic               fp_regwrite,
    input  logic [REGBITS-1:0] fp_dst,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               flush,
    output logic               stall,
    output logic               dp_start,
    output logic [1:0]         dp_op,
    output logic [WIDTH-1:0]   dp_a,
    output logic [WIDTH-1:0]   dp_b,
    input  logic               dp_done,
    input  logic [WIDTH-1:0]   dp_result,
    output logic               wb_valid,
    output logic [REGBITS-1:0] wb_addr,
    output logic [WIDTH-1:0]   wb_data,
    output logic               err
);

    localparam int               c_cnt_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    seq_state_t           r_state;
    seq_state_t           w_next_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_dp_start;
    logic [1:0]           r_dp_op;
    logic [WIDTH-1:0]     r_dp_a;
    logic [WIDTH-1:0]     r_dp_b;
    logic                 r_wb_valid;
    logic [REGBITS-1:0]   r_wb_addr;
    logic [WIDTH-1:0]     r_wb_data;
    logic                 r_err;

    logic                 w_legal;
    logic                 w_is_sign;
    logic                 w_issue;
    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_dp_take;
    logic                 w_timeout;
    logic [WIDTH-1:0]     w_sign_result;

    assign w_legal   = is_legal_fpu_op(fpu_control);
    assign w_is_sign = (fpu_control == FABS) || (fpu_control == FNEG);
    assign w_issue   = (r_state == IDLE) && issue_valid && fp_regwrite && !flush;
    assign w_accept  = w_issue && w_legal;
    assign w_illegal = w_issue && !w_legal;
    // flush outranks dp_done, which in turn outranks the watchdog
    assign w_dp_take = (r_state == WAIT) && !flush && dp_done;
    assign w_timeout = (r_state == WAIT) && !flush && !dp_done && (r_cnt == c_cnt_last);

    assign stall = w_accept || (r_state == WAIT);

    // ABS/NEG result is produced from the operand as it is being latched
    fpu_sign_unit #(
        .WIDTH (WIDTH)
    ) u_sign (
        .a  (op_a),
        .op (fpu_op_t'(fpu_control)),
        .y  (w_sign_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_is_sign ? WB : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    w_next_state = IDLE;
                end else if (dp_done) begin
                    w_next_state = WB;
                end else if (r_cnt == c_cnt_last) begin
                    w_next_state = IDLE;
                end
            end
            WB:      w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_dp_start <= 1'b0;
            r_dp_op    <= '0;
            r_dp_a     <= '0;
            r_dp_b     <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_dp_start <= w_accept && !w_is_sign;
            r_wb_valid <= (w_next_state == WB);
            r_err      <= w_illegal || w_timeout;

            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_dp_op   <= fpu_control[1:0];
                r_dp_a    <= op_a;
                r_dp_b    <= op_b;
                r_wb_addr <= fp_dst;
                if (w_is_sign) begin
                    r_wb_data <= w_sign_result;
                end
            end else if (w_dp_take) begin
                r_wb_data <= dp_result;
            end
        end
    end

    assign dp_start = r_dp_start;
    assign dp_op    = r_dp_op;
    assign dp_a     = r_dp_a;
    assign dp_b     = r_dp_b;
    assign wb_valid = r_wb_valid;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: doc/fpu_issue_seq.md
Name: fpu_issue_seq

Overview:
- Receiving end of the decoder's F-type control interface: consumes `fpu_control`/`fp_regwrite` in EX, sequences the op to completion, stalls the integer pipeline while busy, writes one result to the FP register file.
- NEG/ABS are computed locally; ADD/SUB/MUL/DIV are handed to an external multi-cycle FP datapath over a start/done handshake, guarded by a watchdog.

Parameters:
- WIDTH, 32, operand/result width.
- REGBITS, 5, FP register index width.
- TIMEOUT, 64, max WAIT cycles before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  EX stage holds a valid F-type instruction.
- fpu_control  in  4  op code: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 ABS, 0101 NEG.
- fp_regwrite  in  1  instruction writes an FP register.
- fp_dst  in  REGBITS  destination FP register.
- op_a, op_b  in  WIDTH  source operands.
- flush  in  1  kill the in-flight op.
- stall  out  1  freeze IF/ID/EX.
- dp_start  out  1  one-cycle start pulse to the datapath.
- dp_op  out  2  latched op[1:0] to the datapath.
- dp_a, dp_b  out  WIDTH  latched operands.
- dp_done  in  1  datapath result valid (single cycle).
- dp_result  in  WIDTH  datapath result.
- wb_valid  out  1  FP regfile write enable.
- wb_addr  out  REGBITS  write address.
- wb_data  out  WIDTH  write data.
- err  out  1  one-cycle pulse: illegal op or timeout.

Behaviour:
- Reset (async, reset_n=0): state IDLE, counter 0; stall, dp_start, wb_valid, err = 0; dp_op, dp_a, dp_b, wb_addr, wb_data = 0. Applies mid-operation. A dp_done seen later in IDLE is ignored.
- Legal op = fpu_control in 0000..0101. accept = (state==IDLE) & issue_valid & fp_regwrite & legal & ~flush.
- IDLE, on accept:
  - Latch op, operands and fp_dst.
  - ABS/NEG: next state WB. wb_data = {1'b0, a[WIDTH-2:0]} for ABS, {~a[WIDTH-1], a[WIDTH-2:0]} for NEG.
  - Others: next state WAIT; dp_start=1 in the first WAIT cycle only; counter cleared.
- IDLE, issue_valid & fp_regwrite & illegal & ~flush: err=1 next cycle; stay IDLE; no stall, no writeback.
- WAIT:
  - Counter increments each cycle.
  - dp_done=1: latch dp_result into wb_data, go WB. Takes priority over timeout in the same cycle.
  - Counter==TIMEOUT-1 without dp_done: err=1 next cycle, go IDLE, no writeback.
  - flush=1: go IDLE, no writeback. flush beats dp_done in the same cycle.
- WB: wb_valid=1 for exactly one cycle, go IDLE. flush during WB does not cancel the write (already committed).
- stall = accept | (state==WAIT), combinational.
  - ABS/NEG stall exactly 1 cycle; DIV with done after N WAIT cycles stalls N+1 cycles.
  - stall is 0 in the WB cycle so the pipeline advances as the write happens. The still-present issue_valid in that cycle is not re-accepted because state != IDLE.
- issue_valid while not IDLE: ignored.
- dp_done while not WAIT: ignored.
- Outputs are registered except stall. wb_addr and wb_data hold their values outside WB.

Decomposition:
- Package fpu_pkg:
  - enum fpu_op_t {FADD=4'b0000, FSUB=4'b0001, FMUL=4'b0010, FDIV=4'b0011, FABS=4'b0100, FNEG=4'b0101}.
  - enum seq_state_t {IDLE, WAIT, WB}.
  - Function is_legal_fpu_op.
- Sub-module fpu_sign_unit: combinational ABS/NEG on the latched operand.

Test Plan:
- NEG: op_a=0x3F800000, fp_dst=3 -> stall high 1 cycle; next cycle wb_valid=1, wb_addr=3, wb_data=0xBF800000.
- ABS: op_a=0xC0400000 -> wb_data=0x40400000 one cycle after issue; err stays 0.
- DIV: a=0x41200000, b=0x40000000; model asserts dp_done with 0x40A00000 on the 10th WAIT cycle -> dp_start pulses once, stall high 11 cycles, one wb_valid with 0x40A00000.
- Timeout: TIMEOUT=8, MUL, dp_done never asserted -> err pulse after 8 WAIT cycles, no wb_valid, stall drops, next ADD accepted normally.
- Flush: flush on WAIT cycle 3, dp_done on cycle 5 -> no wb_valid. Also issue_valid & flush together in IDLE -> not accepted, stall 0.
- Illegal op 0111 -> err=1 next cycle, no stall. Separately, reset_n low during WAIT -> all outputs 0 immediately, state IDLE.
